// File: rtl/demux7_buf.sv
// demux7_buf: 1-to-2 routing buffer that steers each input word into one of two per-channel FIFOs.
//   clk        : clock, rising edge
//   rst_n      : asynchronous active-low reset
//   in_valid/in_ready/in_sel/in_data : producer side, in_sel picks channel 0 or 1
//   out0_valid/out0_ready/out0_data  : channel 0 consumer handshake
//   out1_valid/out1_ready/out1_data  : channel 1 consumer handshake
//   DEMUX7_CNT_EN (macro) adds out0_cnt/out1_cnt pop counters and the drop_stall flag
module demux7_buf #(
    parameter int WIDTH = 7,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_sel,
    input  logic [WIDTH-1:0] in_data,
`ifdef DEMUX7_CNT_EN
    output logic [7:0]       out0_cnt,
    output logic [7:0]       out1_cnt,
    output logic             drop_stall,
`endif
    output logic             out0_valid,
    input  logic             out0_ready,
    output logic [WIDTH-1:0] out0_data,
    output logic             out1_valid,
    input  logic             out1_ready,
    output logic [WIDTH-1:0] out1_data
);
    localparam int AW = $clog2(DEPTH);

    logic [AW-1:0]    wp_q [2];
    logic [AW-1:0]    wp_d [2];
    logic [AW-1:0]    rp_q [2];
    logic [AW-1:0]    rp_d [2];
    logic [AW:0]      occ_q [2];
    logic [AW:0]      occ_d [2];
    logic [WIDTH-1:0] mem_q [2][DEPTH];
    logic [WIDTH-1:0] mem_d [2][DEPTH];
    logic [1:0]       full;
    logic [1:0]       vld;
    logic [1:0]       push;
    logic [1:0]       pop;

    // A full target channel stalls the producer even when the other channel has room.
    assign in_ready   = !full[in_sel];
    assign out0_valid = vld[0];
    assign out1_valid = vld[1];
    assign out0_data  = mem_q[0][rp_q[0]];
    assign out1_data  = mem_q[1][rp_q[1]];
    assign pop        = vld & {out1_ready, out0_ready};

    always_comb begin
        for (int c = 0; c < 2; c++) begin
            full[c] = occ_q[c] == (AW+1)'(DEPTH);
            vld[c]  = occ_q[c] != '0;
            push[c] = in_valid && in_ready && (in_sel == c[0]);
        end
        for (int c = 0; c < 2; c++) begin
            wp_d[c]  = wp_q[c] + AW'(push[c]);
            rp_d[c]  = rp_q[c] + AW'(pop[c]);
            occ_d[c] = occ_q[c] + (AW+1)'(push[c]) - (AW+1)'(pop[c]);
        end
        mem_d = mem_q;
        if (push[in_sel]) mem_d[in_sel][wp_q[in_sel]] = in_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int c = 0; c < 2; c++) begin
                wp_q[c]  <= '0;
                rp_q[c]  <= '0;
                occ_q[c] <= '0;
                for (int i = 0; i < DEPTH; i++) mem_q[c][i] <= '0;
            end
        end else begin
            wp_q  <= wp_d;
            rp_q  <= rp_d;
            occ_q <= occ_d;
            mem_q <= mem_d;
        end
    end

`ifdef DEMUX7_CNT_EN
    logic [7:0] pcnt_q [2];
    logic [7:0] pcnt_d [2];
    logic       drop_stall_q;
    logic       drop_stall_d;

    assign out0_cnt   = pcnt_q[0];
    assign out1_cnt   = pcnt_q[1];
    assign drop_stall = drop_stall_q;

    always_comb begin
        for (int c = 0; c < 2; c++) pcnt_d[c] = pcnt_q[c] + 8'(pop[c]);
        drop_stall_d = in_valid && !in_ready;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pcnt_q[0]    <= '0;
            pcnt_q[1]    <= '0;
            drop_stall_q <= 1'b0;
        end else begin
            pcnt_q       <= pcnt_d;
            drop_stall_q <= drop_stall_d;
        end
    end
`endif
endmodule
